// File: rtl/game_pkg.sv
// game_pkg: shared game states, board-size limits and the size-clamping helper.
// Exports:
//   game_state_t       - controller state enum (IDLE, PLAY, CHECK, FLASH, WON)
//   BOARD_SIZE_MIN/MAX - legal range of the board size N
//   BOARD_SIZE_DEFAULT - N used after reset and for out-of-range requests
//   clamp_board_size   - maps a requested N onto a legal N
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK,
        S_FLASH,
        S_WON
    } game_state_t;

    localparam logic [2:0] BOARD_SIZE_MIN     = 3'd2;
    localparam logic [2:0] BOARD_SIZE_MAX     = 3'd5;
    localparam logic [2:0] BOARD_SIZE_DEFAULT = 3'd3;

    function automatic logic [2:0] clamp_board_size(input logic [2:0] sel);
        return (sel >= BOARD_SIZE_MIN && sel <= BOARD_SIZE_MAX) ? sel : BOARD_SIZE_DEFAULT;
    endfunction

endpackage

// File: rtl/game_board_ctl_wrap_counter.sv
// wrap_counter: one cursor axis, counting 0..limit-1 with wrap-around.
// Ports:
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_clear      - force the value to 0
//   i_inc, i_dec - one-cycle move strobes; both at once cancel
//   i_limit      - number of cells on this axis (M = N*N)
//   o_value      - registered cursor coordinate
module wrap_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic [4:0] i_limit,
    output logic [4:0] o_value
);

    logic [4:0] r_value;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear)
            r_value <= '0;
        else if (i_inc && !i_dec)
            r_value <= (r_value == i_limit - 5'd1) ? 5'd0 : r_value + 5'd1;
        else if (i_dec && !i_inc)
            r_value <= (r_value == 5'd0) ? i_limit - 5'd1 : r_value - 5'd1;
    end

    assign o_value = r_value;

endmodule

// File: rtl/game_board_ctl.sv
// game_board_ctl: game sequencing FSM, board-size latch, cursor and validator handshake.
// Ports:
//   i_clk, i_rst                     - pixel clock, synchronous active-high reset
//   i_start, i_quit                  - begin / abandon a game (strobes)
//   i_size_sel                       - requested board size, sampled on start
//   i_key_up/down/left/right         - cursor move strobes
//   i_check_req                      - request a solution check (strobe)
//   i_check_done, i_check_ok         - validator result strobe and verdict
//   o_check_start                    - one-cycle pulse to the validator
//   o_is_game_on, o_board_size       - overlay enable and latched N
//   o_incorrect, o_won               - failed-check highlight, solved flag
//   o_cursor_x, o_cursor_y           - cursor cell, 0..N*N-1
module game_board_ctl
    import game_pkg::*;
#(
    parameter int FLASH_CYCLES = 32_500_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_quit,
    input  logic [2:0] i_size_sel,
    input  logic       i_key_up,
    input  logic       i_key_down,
    input  logic       i_key_left,
    input  logic       i_key_right,
    input  logic       i_check_req,
    input  logic       i_check_done,
    input  logic       i_check_ok,
    output logic       o_check_start,
    output logic       o_is_game_on,
    output logic [2:0] o_board_size,
    output logic       o_incorrect,
    output logic       o_won,
    output logic [4:0] o_cursor_x,
    output logic [4:0] o_cursor_y
);

    localparam int             FW         = $clog2(FLASH_CYCLES + 1);
    localparam logic [FW-1:0]  FLASH_LOAD = FW'(FLASH_CYCLES - 1);

    game_state_t   r_state, w_next;
    logic [FW-1:0] r_flash, w_flash_next;
    logic [2:0]    r_board_size;
    logic          r_check_start, r_is_game_on, r_incorrect, r_won;
    logic          w_check_start, w_clear, w_move;
    logic [4:0]    w_limit;

    always_comb begin
        w_next        = r_state;
        w_flash_next  = r_flash;
        w_check_start = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_PLAY;
            S_PLAY:  if (i_check_req) begin
                         w_next        = S_CHECK;
                         w_check_start = 1'b1;
                     end
            // A result arriving alongside our own check_start pulse predates the request.
            S_CHECK: if (i_check_done && !r_check_start) begin
                         w_next = i_check_ok ? S_WON : S_FLASH;
                         if (!i_check_ok) w_flash_next = FLASH_LOAD;
                     end
            S_FLASH: if (r_flash == '0) w_next = S_PLAY;
                     else w_flash_next = r_flash - 1'b1;
            S_WON:   if (i_start) w_next = S_PLAY;
            default: w_next = S_IDLE;
        endcase
        if (i_quit && r_state != S_IDLE) begin
            w_next        = S_IDLE;
            w_check_start = 1'b0;
            w_flash_next  = '0;
        end
    end

    // A fresh game (from IDLE or WON) relatches N and homes the cursor.
    assign w_clear = (w_next == S_PLAY) && (r_state == S_IDLE || r_state == S_WON);
    assign w_move  = (r_state == S_PLAY || r_state == S_FLASH) && !i_quit;
    assign w_limit = {2'b00, r_board_size} * {2'b00, r_board_size};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_flash       <= '0;
            r_board_size  <= BOARD_SIZE_DEFAULT;
            r_check_start <= 1'b0;
            r_is_game_on  <= 1'b0;
            r_incorrect   <= 1'b0;
            r_won         <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_flash       <= w_flash_next;
            if (w_clear) r_board_size <= clamp_board_size(i_size_sel);
            r_check_start <= w_check_start;
            r_is_game_on  <= (w_next != S_IDLE);
            r_incorrect   <= (w_next == S_FLASH);
            r_won         <= (w_next == S_WON);
        end
    end

    wrap_counter u_cursor_x (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_clear),
        .i_inc   (w_move && i_key_right),
        .i_dec   (w_move && i_key_left),
        .i_limit (w_limit),
        .o_value (o_cursor_x)
    );

    wrap_counter u_cursor_y (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_clear),
        .i_inc   (w_move && i_key_down),
        .i_dec   (w_move && i_key_up),
        .i_limit (w_limit),
        .o_value (o_cursor_y)
    );

    assign o_check_start = r_check_start;
    assign o_is_game_on  = r_is_game_on;
    assign o_board_size  = r_board_size;
    assign o_incorrect   = r_incorrect;
    assign o_won         = r_won;

endmodule

// File: tb/tb_game_board_ctl.sv
// tb_game_board_ctl: vector table, corner sequences and random run against a reference model.
module tb_game_board_ctl;

    localparam int F = 4;

    logic       clk = 1'b0;
    logic       rst, start, quit, ku, kd, kl, kr, req, done, ok;
    logic [2:0] sel;
    logic       o_check_start, o_is_game_on, o_incorrect, o_won;
    logic [2:0] o_board_size;
    logic [4:0] o_cursor_x, o_cursor_y;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_board_ctl #(.FLASH_CYCLES(F)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_quit       (quit),
        .i_size_sel   (sel),
        .i_key_up     (ku),
        .i_key_down   (kd),
        .i_key_left   (kl),
        .i_key_right  (kr),
        .i_check_req  (req),
        .i_check_done (done),
        .i_check_ok   (ok),
        .o_check_start(o_check_start),
        .o_is_game_on (o_is_game_on),
        .o_board_size (o_board_size),
        .o_incorrect  (o_incorrect),
        .o_won        (o_won),
        .o_cursor_x   (o_cursor_x),
        .o_cursor_y   (o_cursor_y)
    );

    // Reference model: game phase plus remaining flash cycles and plain modular cursor arithmetic.
    // phase 0 idle, 1 play, 2 checking, 3 flashing, 4 won
    int m_phase = 0, m_left = 0, m_n = 3, m_x = 0, m_y = 0;
    bit m_cs = 0;

    function automatic int legal_n(int s);
        return (s >= 2 && s <= 5) ? s : 3;
    endfunction

    task automatic model_move();
        int m = m_n * m_n;
        m_x = (m_x + int'(kr) - int'(kl) + m) % m;
        m_y = (m_y + int'(kd) - int'(ku) + m) % m;
    endtask

    task automatic model_step();
        bit was_cs = m_cs;
        m_cs = 0;
        if (rst) begin
            m_phase = 0; m_left = 0; m_n = 3; m_x = 0; m_y = 0;
        end else if (quit && m_phase != 0) begin
            m_phase = 0;
        end else if ((m_phase == 0 || m_phase == 4) && start) begin
            m_phase = 1; m_n = legal_n(int'(sel)); m_x = 0; m_y = 0;
        end else if (m_phase == 1) begin
            model_move();
            if (req) begin m_phase = 2; m_cs = 1; end
        end else if (m_phase == 2 && done && !was_cs) begin
            if (ok) m_phase = 4;
            else begin m_phase = 3; m_left = F; end
        end else if (m_phase == 3) begin
            model_move();
            m_left--;
            if (m_left == 0) m_phase = 1;
        end
    endtask

    function automatic logic [16:0] ex(bit on, bit inc, bit wn, bit cs, int sz, int x, int y);
        return {on, inc, wn, cs, 3'(sz), 5'(x), 5'(y)};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {o_is_game_on, o_incorrect, o_won, o_check_start, o_board_size, o_cursor_x, o_cursor_y};
    endfunction

    function automatic logic [16:0] model_vec();
        return ex(m_phase != 0, m_phase == 3, m_phase == 4, m_cs, m_n, m_x, m_y);
    endfunction

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got on/inc/won/cs/size/x/y=%b_%b_%b_%b_%0d_%0d_%0d expected %b_%b_%b_%b_%0d_%0d_%0d",
                     name, act[16], act[15], act[14], act[13], act[12:10], act[9:5], act[4:0],
                     exp[16], exp[15], exp[14], exp[13], exp[12:10], exp[9:5], exp[4:0]);
        end
    endtask

    task automatic clr();
        {rst, start, quit, ku, kd, kl, kr, req, done, ok} = '0;
        sel = 3'd0;
    endtask

    task automatic tick(input string name);
        model_step();
        @(posedge clk);
        #1;
        chk({name, "/model"}, dut_vec(), model_vec());
    endtask

    typedef struct {
        string      name;
        bit         st, qt, u, d, l, r, rq, cd, okv;
        int         sel;
        logic [16:0] exp;
    } vec_t;

    function automatic vec_t mk(string name, bit st, bit qt, bit u, bit d, bit l, bit r,
                                bit rq, bit cd, bit okv, int s, logic [16:0] e);
        vec_t v;
        v.name = name; v.st = st; v.qt = qt; v.u = u; v.d = d; v.l = l; v.r = r;
        v.rq = rq; v.cd = cd; v.okv = okv; v.sel = s; v.exp = e;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        //                      st qt u  d  l  r  rq cd ok sel   on in wn cs sz x  y
        tbl.push_back(mk("start3",  1,0,0,0,0,0,0,0,0,3, ex(1,0,0,0,3,0,0)));
        tbl.push_back(mk("quit_a",  0,1,0,0,0,0,0,0,0,0, ex(0,0,0,0,3,0,0)));
        tbl.push_back(mk("start7",  1,0,0,0,0,0,0,0,0,7, ex(1,0,0,0,3,0,0)));
        tbl.push_back(mk("quit_b",  0,1,0,0,0,0,0,0,0,0, ex(0,0,0,0,3,0,0)));
        tbl.push_back(mk("start5",  1,0,0,0,0,0,0,0,0,5, ex(1,0,0,0,5,0,0)));
        tbl.push_back(mk("quit_c",  0,1,0,0,0,0,0,0,0,0, ex(0,0,0,0,5,0,0)));
        tbl.push_back(mk("start2",  1,0,0,0,0,0,0,0,0,2, ex(1,0,0,0,2,0,0)));
        tbl.push_back(mk("right1",  0,0,0,0,0,1,0,0,0,0, ex(1,0,0,0,2,1,0)));
        tbl.push_back(mk("right2",  0,0,0,0,0,1,0,0,0,0, ex(1,0,0,0,2,2,0)));
        tbl.push_back(mk("right3",  0,0,0,0,0,1,0,0,0,0, ex(1,0,0,0,2,3,0)));
        tbl.push_back(mk("right_wr",0,0,0,0,0,1,0,0,0,0, ex(1,0,0,0,2,0,0)));
        tbl.push_back(mk("left_wr", 0,0,0,0,1,0,0,0,0,0, ex(1,0,0,0,2,3,0)));
        tbl.push_back(mk("updn",    0,0,1,1,0,0,0,0,0,0, ex(1,0,0,0,2,3,0)));
        tbl.push_back(mk("rt_dn",   0,0,0,1,0,1,0,0,0,0, ex(1,0,0,0,2,0,1)));
        tbl.push_back(mk("up1",     0,0,1,0,0,0,0,0,0,0, ex(1,0,0,0,2,0,0)));
        tbl.push_back(mk("up_wr",   0,0,1,0,0,0,0,0,0,0, ex(1,0,0,0,2,0,3)));
        tbl.push_back(mk("done_pl", 0,0,0,0,0,0,0,1,1,0, ex(1,0,0,0,2,0,3)));
        tbl.push_back(mk("req",     0,0,0,0,0,0,1,0,0,0, ex(1,0,0,1,2,0,3)));
        tbl.push_back(mk("done_ear",0,0,0,0,0,0,0,1,1,0, ex(1,0,0,0,2,0,3)));
        tbl.push_back(mk("bad_rt",  0,0,0,0,0,1,0,1,0,0, ex(1,1,0,0,2,0,3)));
        tbl.push_back(mk("fl_rt",   0,0,0,0,0,1,0,0,0,0, ex(1,1,0,0,2,1,3)));
        tbl.push_back(mk("fl_req",  0,0,0,0,0,0,1,0,0,0, ex(1,1,0,0,2,1,3)));
        tbl.push_back(mk("fl_4",    0,0,0,0,0,0,0,0,0,0, ex(1,1,0,0,2,1,3)));
        tbl.push_back(mk("fl_end",  0,0,0,0,0,0,0,0,0,0, ex(1,0,0,0,2,1,3)));
        tbl.push_back(mk("req2",    0,0,0,0,0,0,1,0,0,0, ex(1,0,0,1,2,1,3)));
        tbl.push_back(mk("wait",    0,0,0,0,0,0,0,0,0,0, ex(1,0,0,0,2,1,3)));
        tbl.push_back(mk("good",    0,0,0,0,0,0,0,1,1,0, ex(1,0,1,0,2,1,3)));
        tbl.push_back(mk("restart", 1,0,0,0,0,0,0,0,0,2, ex(1,0,0,0,2,0,0)));
        tbl.push_back(mk("st_play", 1,0,0,0,0,1,0,0,0,5, ex(1,0,0,0,2,1,0)));
        tbl.push_back(mk("quit_d",  0,1,0,0,0,0,0,0,0,0, ex(0,0,0,0,2,1,0)));

        clr();
        rst = 1'b1;
        tick("rst0");
        tick("rst1");
        chk("reset", dut_vec(), ex(0,0,0,0,3,0,0));
        rst = 1'b0;

        foreach (tbl[i]) begin
            clr();
            start = tbl[i].st; quit = tbl[i].qt; ku = tbl[i].u; kd = tbl[i].d;
            kl = tbl[i].l; kr = tbl[i].r; req = tbl[i].rq; done = tbl[i].cd;
            ok = tbl[i].okv; sel = 3'(tbl[i].sel);
            tick(tbl[i].name);
            chk(tbl[i].name, dut_vec(), tbl[i].exp);
        end

        // quit in the middle of a flash, then a stale verdict
        clr(); start = 1; sel = 3; tick("a_start");
        clr(); req = 1; tick("a_req");
        clr(); tick("a_wait");
        clr(); done = 1; tick("a_bad");
        chk("a_flash", {o_is_game_on, o_incorrect}, 17'b11);
        clr(); tick("a_fl2");
        clr(); quit = 1; tick("a_quit");
        chk("a_quit_out", {o_is_game_on, o_incorrect, o_won}, 17'b000);
        clr(); done = 1; ok = 1; tick("a_stale");
        chk("a_stale_out", {o_is_game_on, o_won}, 17'b00);

        // reset while waiting for a verdict, then the verdict arrives
        clr(); start = 1; sel = 4; tick("b_start");
        clr(); kr = 1; kd = 1; tick("b_move");
        clr(); req = 1; tick("b_req");
        clr(); tick("b_wait");
        clr(); rst = 1; tick("b_rst");
        clr(); done = 1; ok = 1; tick("b_late");
        chk("b_after_rst", dut_vec(), ex(0,0,0,0,3,0,0));
        clr(); done = 1; tick("c_idle_done");
        chk("c_idle_done", dut_vec(), ex(0,0,0,0,3,0,0));

        // random run checked cycle by cycle against the model
        for (int c = 0; c < 4000; c++) begin
            clr();
            rst   = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 29) == 0);
            quit  = ($urandom_range(0, 59) == 0);
            ku    = ($urandom_range(0, 3) == 0);
            kd    = ($urandom_range(0, 3) == 0);
            kl    = ($urandom_range(0, 3) == 0);
            kr    = ($urandom_range(0, 3) == 0);
            req   = ($urandom_range(0, 7) == 0);
            done  = ($urandom_range(0, 3) == 0);
            ok    = ($urandom_range(0, 2) == 0);
            sel   = 3'($urandom_range(0, 7));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_board_ctl.md
# game_board_ctl

Sequencing controller for the game board overlay. It owns the game state machine and latches the board size at game start. It tracks the cell cursor and runs the check handshake with an external solution validator. It drives `is_game_on`, `board_size` and `incorrect` into the board-draw stage of the VGA pipeline, and exports the cursor for the cell/highlight draw stages.

## Interface
- `FLASH_CYCLES`, default 32_500_000: cycles `incorrect` is held after a failed check (0.5 s at 65 MHz).
- `clk`  in  1: pixel clock, 65 MHz.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: one-cycle strobe; begin a game.
- `quit`  in  1: one-cycle strobe; abandon the game.
- `size_sel`  in  3: requested board size N, sampled on `start`.
- `key_up`, `key_down`, `key_left`, `key_right`  in  1 each: one-cycle cursor move strobes.
- `check_req`  in  1: one-cycle strobe; request a solution check.
- `check_done`  in  1: validator result valid, one-cycle strobe.
- `check_ok`  in  1: validator verdict, qualified by `check_done`.
- `check_start`  out  1: one-cycle pulse to the validator.
- `is_game_on`  out  1: board overlay enable.
- `board_size`  out  3: latched N.
- `incorrect`  out  1: failed-check highlight.
- `won`  out  1: solved flag.
- `cursor_x`, `cursor_y`  out  5 each: cursor cell, range 0..N²-1.

## Operation
- States: IDLE, PLAY, CHECK, FLASH, WON.
- IDLE:
  - On `start`, latch `board_size` = `size_sel` if 2..5, else 3.
  - Clear the cursor to (0,0) and go to PLAY.
- PLAY:
  - Move strobes update the cursor.
  - On `check_req`, pulse `check_start` and go to CHECK.
- CHECK:
  - Wait for `check_done`. `check_ok`=1 goes to WON; otherwise load the flash counter with FLASH_CYCLES-1 and go to FLASH.
  - Move and `check_req` strobes are ignored. There is no timeout.
- FLASH:
  - Count down. At 0, return to PLAY.
  - Move strobes are honoured. `check_req` is ignored.
- WON: hold until `quit` or `start`.
  - `start` re-enters PLAY with a fresh size and cursor. This applies from WON only; `start` is ignored in PLAY, CHECK and FLASH.
- `quit` in any non-IDLE state goes to IDLE and has priority over every other input that cycle.
- Cursor rules, with M = N²:
  - `key_right` at M-1 wraps to 0; `key_left` at 0 wraps to M-1. Same for `key_down`/`key_up` on `cursor_y`.
  - Axes are independent; a horizontal and a vertical strobe in the same cycle both apply.
  - Opposite strobes on one axis in the same cycle cancel, leaving no move on that axis.
- Outputs by state:
  - `is_game_on` = 1 in PLAY, CHECK, FLASH and WON.
  - `incorrect` = 1 in FLASH only.
  - `won` = 1 in WON only.
- `board_size` is constant from game start until the next `start`. It retains its value in IDLE.
- `check_done` outside CHECK is ignored.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `board_size`=3, cursor (0,0), `check_start`=0, `is_game_on`=0, `incorrect`=0, `won`=0, flash counter 0.
- Strobe at edge t produces its state or output change visible after edge t+1. Latency is 1 cycle.
- `check_start` is high exactly one cycle, concurrent with the first CHECK cycle.
- `check_done` in the same cycle as `check_start` is not accepted; it is accepted from the next cycle.
- `incorrect` stays high for exactly FLASH_CYCLES cycles.
- `rst` or `quit` mid-FLASH or mid-CHECK has these effects:
  - It aborts immediately; outputs drop on the next edge.
  - A later `check_done` is discarded.
- Flash counter width is $clog2(FLASH_CYCLES+1). M is computed as 5 bits (max 25).

## Structure
- Shared package `game_pkg` holds:
  - the state enum `game_state_t`;
  - `BOARD_SIZE_MIN`=2, `BOARD_SIZE_MAX`=5 and `BOARD_SIZE_DEFAULT`=3.
  - The board-draw stage imports the same constants.
- Sub-module `wrap_counter`, instantiated twice (x and y):
  - Inputs: `clk`, `rst`, `clear`, `inc`, `dec`, `limit[4:0]`.
  - Output: `value[4:0]`.
  - Implements the wrap and cancel rules.
- FSM, flash counter and output registers live in `game_board_ctl`.

## Test plan
- Reset, then `start` with `size_sel`=3:
  - `is_game_on`=1 and `board_size`=3 one cycle later; cursor (0,0).
  - `size_sel`=7 latches 3; `size_sel`=5 latches 5.
- N=2: four `key_right` strobes take `cursor_x` 1,2,3,0. `key_left` at 0 gives 3. `key_up`+`key_down` in one cycle leaves y unchanged. `key_right`+`key_down` moves both.
- N=3, FLASH_CYCLES=4:
  - `check_req` gives a single-cycle `check_start`.
  - `check_done`=1 with `check_ok`=0 gives `incorrect`=1 for exactly 4 cycles, then PLAY.
  - A `check_req` during FLASH produces no `check_start`.
- `check_done` with `check_ok`=1 sets `won`=1 and keeps `is_game_on`=1. A following `start` with `size_sel`=2 clears `won`, sets `board_size`=2 and resets the cursor.
- Abort:
  - `quit` mid-FLASH drops `is_game_on` and `incorrect` next cycle.
  - `rst` asserted during CHECK, then `check_done`, leaves the block in IDLE with all outputs at reset values.
- `check_done` strobed while in PLAY or IDLE causes no state change.
